// File: rtl/uart_tx_arbiter.sv
// Purpose : share one UART TX character channel between two requesters, per-line round robin.
// Latency : write in cycle 0 into an idle system -> out_we pulse in cycle 3; max 1 char / 2 cycles.
// Backpres: out_full stalls pops (grant held); reqn_full back-pressures writers, writes while full drop.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   req0_char/we/full       requester 0 (CPU I/O path) char, write strobe, FIFO full
//   req1_char/we/full       requester 1 (monitor/debug) char, write strobe, FIFO full
//   out_char/we, out_full   character channel into uart_top and its TX-full flag
//   ovf                     sticky per-requester overflow (write seen while full)
//   grant                   one-hot current owner, 2'b00 when idle

// Small show-ahead FIFO; full is a flop, empty decodes the count register.
module uart_tx_fifo #(
   parameter int DW = 8,
   parameter int AW = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr_vld,
   input  logic [DW-1:0] wr_dat,
   output logic          full,
   input  logic          rd_rdy,
   output logic [DW-1:0] rd_dat,
   output logic          empty
);
   localparam int DEPTH = 1 << AW;
   localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count, count_nxt;
   logic          do_wr, do_rd;

   assign do_wr  = wr_vld && !full;
   assign do_rd  = rd_rdy && !empty;
   assign empty  = (count == '0);
   assign rd_dat = mem[rd_ptr];

   always_comb begin
      count_nxt = count;
      case ({do_wr, do_rd})
         2'b10:   count_nxt = count + CNT_ONE;
         2'b01:   count_nxt = count - CNT_ONE;
         default: count_nxt = count;
      endcase
   end

   // Storage needs no reset: the pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_dat;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
         count <= count_nxt;
         full  <= (count_nxt == DEPTH_C);
      end
   end
endmodule

module uart_tx_arbiter #(
   parameter int         FAW     = 3,
   parameter int         LOCK_TO = 64,
   parameter logic [7:0] EOL     = 8'h0a
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] req0_char,
   input  logic       req0_we,
   output logic       req0_full,
   input  logic [7:0] req1_char,
   input  logic       req1_we,
   output logic       req1_full,
   output logic [7:0] out_char,
   output logic       out_we,
   input  logic       out_full,
   output logic [1:0] ovf,
   output logic [1:0] grant
);
   localparam int CW = $clog2(LOCK_TO + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_TO - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

   state_t        state, state_nxt;
   logic          last, last_nxt;
   logic [CW-1:0] idle_cnt, cnt_nxt;
   logic          f0_empty, f1_empty;
   logic [7:0]    f0_dat, f1_dat;
   logic          own_empty, pop, pop0, pop1;
   logic [7:0]    head;

   uart_tx_fifo #(.DW(8), .AW(FAW)) u_fifo0 (
      .clk    (clk),
      .rst_n  (rst_n),
      .wr_vld (req0_we),
      .wr_dat (req0_char),
      .full   (req0_full),
      .rd_rdy (pop0),
      .rd_dat (f0_dat),
      .empty  (f0_empty)
   );

   uart_tx_fifo #(.DW(8), .AW(FAW)) u_fifo1 (
      .clk    (clk),
      .rst_n  (rst_n),
      .wr_vld (req1_we),
      .wr_dat (req1_char),
      .full   (req1_full),
      .rd_rdy (pop1),
      .rd_dat (f1_dat),
      .empty  (f1_empty)
   );

   always_comb begin
      state_nxt = state;
      last_nxt  = last;
      cnt_nxt   = idle_cnt;
      own_empty = 1'b1;
      head      = f0_dat;
      pop       = 1'b0;
      pop0      = 1'b0;
      pop1      = 1'b0;
      case (state)
         IDLE: begin
            cnt_nxt = '0;
            // last==1 means requester 1 had the previous line, so requester 0 wins ties.
            if (!f0_empty && (last || f1_empty)) state_nxt = GNT0;
            else if (!f1_empty)                  state_nxt = GNT1;
         end
         GNT0, GNT1: begin
            own_empty = (state == GNT1) ? f1_empty : f0_empty;
            head      = (state == GNT1) ? f1_dat   : f0_dat;
            // Skipping the cycle after a pulse absorbs the one-cycle lag of out_full.
            pop  = !own_empty && !out_full && !out_we;
            pop0 = pop && (state == GNT0);
            pop1 = pop && (state == GNT1);
            if (own_empty) begin
               // Only an empty owner FIFO ages the lock; an out_full stall does not.
               if (idle_cnt == CNT_LAST) begin
                  state_nxt = IDLE;
                  last_nxt  = (state == GNT1);
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = idle_cnt + CNT_ONE;
               end
            end else begin
               cnt_nxt = '0;
               if (pop && (head == EOL)) begin
                  state_nxt = IDLE;
                  last_nxt  = (state == GNT1);
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         last     <= 1'b1;
         idle_cnt <= '0;
         out_char <= 8'h00;
         out_we   <= 1'b0;
         ovf      <= 2'b00;
      end else begin
         state    <= state_nxt;
         last     <= last_nxt;
         idle_cnt <= cnt_nxt;
         out_we   <= pop;
         if (pop) out_char <= head;
         ovf[0] <= ovf[0] | (req0_we & req0_full);
         ovf[1] <= ovf[1] | (req1_we & req1_full);
      end
   end

   assign grant = {state == GNT1, state == GNT0};
endmodule
